// File: rtl/pwm_bus_arbiter.sv
// Two-master round-robin arbiter in front of the PWM register block.
// Each grant runs a fixed IDLE -> BUS -> ACK sequence (ack two cycles after the request is sampled).
module pwm_bus_arbiter #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_i,
   input  logic          m0_wr_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_ack_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_wr_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic          m1_ack_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          acc_en_o,
   output logic          wr_en_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] wdata_o,
   input  logic [DW-1:0] rdata_i,
   output logic          busy_o
);

   typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          ptr;
   logic          win;
   logic          wr_q;
   logic          gnt1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;

   // m1 wins when it is the only requester or the pointer favours it
   assign gnt1 = m1_req_i & (~m0_req_i | ptr);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (m0_req_i | m1_req_i) state_nxt = BUS;
         BUS:     state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr     <= 1'b0;
         win     <= 1'b0;
         wr_q    <= 1'b0;
         addr_o  <= '0;
         wdata_o <= '0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req_i | m1_req_i) begin
                  win     <= gnt1;
                  wr_q    <= gnt1 ? m1_wr_i    : m0_wr_i;
                  addr_o  <= gnt1 ? m1_addr_i  : m0_addr_i;
                  wdata_o <= gnt1 ? m1_wdata_i : m0_wdata_i;
               end
            end
            BUS: begin
               if (!wr_q) begin
                  if (win) rdata1 <= rdata_i;
                  else     rdata0 <= rdata_i;
               end
            end
            ACK:     ptr <= ~win;
            default: ;
         endcase
      end
   end

   assign acc_en_o   = (state == BUS);
   assign wr_en_o    = acc_en_o & wr_q;
   assign m0_ack_o   = (state == ACK) & ~win;
   assign m1_ack_o   = (state == ACK) & win;
   assign busy_o     = (state != IDLE);
   assign m0_rdata_o = rdata0;
   assign m1_rdata_o = rdata1;

endmodule

// File: tb/tb_pwm_bus_arbiter.sv
// Bench for pwm_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model that predicts every output from grant timing arithmetic.
module tb_pwm_bus_arbiter;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_wr, m1_req, m1_wr;
   logic [AW-1:0] m0_addr, m1_addr, addr;
   logic [DW-1:0] m0_wdata, m1_wdata, wdata, rdata_in;
   logic          m0_ack, m1_ack, acc_en, wr_en, busy;
   logic [DW-1:0] m0_rdata, m1_rdata;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pwm_bus_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
      .acc_en_o(acc_en), .wr_en_o(wr_en), .addr_o(addr), .wdata_o(wdata),
      .rdata_i(rdata_in), .busy_o(busy)
   );

   // Transaction model: a grant taken at edge g gives an access cycle after g,
   // an ack cycle after g+1, and the arbiter is free again after g+2.
   int            edge_n = 0;
   bit            active = 0;
   int            gnt_e  = 0;
   bit            g_win, g_wr, rr_ptr;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h at edge %0d", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_edge();
      edge_n++;
      if (rst) begin
         active = 0; rr_ptr = 0;
         e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (active && edge_n == gnt_e + 1) begin
         if (!g_wr) begin
            if (g_win) e_rd1 = rdata_in;
            else       e_rd0 = rdata_in;
         end
      end else if (active && edge_n == gnt_e + 2) begin
         rr_ptr = !g_win;
         active = 0;
      end else if (!active && (m0_req || m1_req)) begin
         g_win   = (m0_req && m1_req) ? rr_ptr : m1_req;
         g_wr    = g_win ? m1_wr    : m0_wr;
         e_addr  = g_win ? m1_addr  : m0_addr;
         e_wdata = g_win ? m1_wdata : m0_wdata;
         gnt_e   = edge_n;
         active  = 1;
      end
   endtask

   task automatic check_outputs();
      bit in_bus, in_ack;
      in_bus = active && (edge_n == gnt_e);
      in_ack = active && (edge_n == gnt_e + 1);
      check("busy",     busy,     active);
      check("acc_en",   acc_en,   in_bus);
      check("wr_en",    wr_en,    in_bus && g_wr);
      check("addr",     addr,     e_addr);
      check("wdata",    wdata,    e_wdata);
      check("m0_ack",   m0_ack,   in_ack && !g_win);
      check("m1_ack",   m1_ack,   in_ack && g_win);
      check("m0_rdata", m0_rdata, e_rd0);
      check("m1_rdata", m1_rdata, e_rd1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; rdata_in = '0;
   endtask

   initial begin
      logic [DW-1:0] saved_rd0;
      int            last_ack;
      int            waited;
      bit            got_ack;

      idle_inputs();
      rst = 1;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_acc", acc_en, 0);
      check("rst_m0rd", m0_rdata, 0);
      rst = 0;
      tick();

      // single write from m0
      m0_req = 1; m0_wr = 1; m0_addr = 3'd2; m0_wdata = 16'h01F4;
      tick();
      check("wr_acc", acc_en, 1);
      check("wr_en", wr_en, 1);
      check("wr_addr", addr, 2);
      check("wr_data", wdata, 16'h01F4);
      tick();
      check("wr_m0ack", m0_ack, 1);
      check("wr_m1ack", m1_ack, 0);
      m0_req = 0;
      tick();

      // single read from m1
      saved_rd0 = m0_rdata;
      m1_req = 1; m1_wr = 0; m1_addr = 3'd5;
      tick();
      check("rd_acc", acc_en, 1);
      check("rd_wren", wr_en, 0);
      rdata_in = 16'h0123;
      tick();
      check("rd_m1ack", m1_ack, 1);
      check("rd_m1data", m1_rdata, 16'h0123);
      check("rd_m0data", m0_rdata, saved_rd0);
      m1_req = 0; rdata_in = '0;
      tick();

      // inputs changed after grant are ignored
      m0_req = 1; m0_wr = 1; m0_addr = 3'd1; m0_wdata = 16'hAAAA;
      tick();
      m0_wdata = 16'h5555;
      check("hold_wdata", wdata, 16'hAAAA);
      tick();
      check("hold_wdata2", wdata, 16'hAAAA);
      m0_req = 0;
      tick();

      // m1 pulses req only while m0 is being served
      m0_req = 1; m0_wr = 0; m0_addr = 3'd4;
      tick();
      m1_req = 1;
      tick();
      m1_req = 0; m0_req = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drop_m1ack", m1_ack, 0);
      end

      // reset during BUS aborts the access
      m0_req = 1; m0_wr = 1; m0_addr = 3'd6; m0_wdata = 16'h1234;
      tick();
      check("abort_acc", acc_en, 1);
      rst = 1; m0_req = 0;
      tick();
      check("abort_acc0", acc_en, 0);
      check("abort_addr", addr, 0);
      check("abort_wdata", wdata, 0);
      rst = 0;
      tick();
      check("abort_noack", m0_ack | m1_ack, 0);

      // constant contention after reset: m0, m1, m0, m1, three cycles apart
      m0_req = 1; m1_req = 1; m0_wr = 1; m1_wr = 1;
      last_ack = 0;
      for (int k = 0; k < 4; k++) begin
         got_ack = 0;
         waited  = 0;
         while (!got_ack && waited < 8) begin
            tick();
            waited++;
            got_ack = m0_ack | m1_ack;
         end
         check("cont_ack_seen", got_ack, 1);
         check("cont_m1_wins", m1_ack, k % 2);
         if (k > 0) check("cont_spacing", edge_n - last_ack, 3);
         last_ack = edge_n;
      end
      idle_inputs();
      tick();
      tick();

      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 99) < 2);
         m0_req   = ($urandom_range(0, 3) != 0);
         m1_req   = ($urandom_range(0, 3) != 0);
         m0_wr    = $urandom_range(0, 1);
         m1_wr    = $urandom_range(0, 1);
         m0_addr  = AW'($urandom);
         m1_addr  = AW'($urandom);
         m0_wdata = DW'($urandom);
         m1_wdata = DW'($urandom);
         rdata_in = DW'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_bus_arbiter.md
PWM_BUS_ARBITER -- requirements
Module: pwm_bus_arbiter

Interface
REQ-001 Parameter DW, default 16, register-bus data width.
REQ-002 Parameter AW, default 3, register-bus address width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as below.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 m0_req_i / m1_req_i  input  1 each  level request, held until the matching ack.
REQ-007 m0_wr_i / m1_wr_i  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr_i / m1_addr_i  input  AW each  target register address.
REQ-009 m0_wdata_i / m1_wdata_i  input  DW each  write data.
REQ-010 m0_ack_o / m1_ack_o  output  1 each  one-cycle completion pulse.
REQ-011 m0_rdata_o / m1_rdata_o  output  DW each  read data; valid while ack is high, held until that master's next read ack.
REQ-012 acc_en_o  output  1  access enable to the PWM register block.
REQ-013 wr_en_o  output  1  write enable to the register block.
REQ-014 addr_o  output  AW  address to the register block.
REQ-015 wdata_o  output  DW  write data to the register block.
REQ-016 rdata_i  input  DW  register-block read data, combinationally valid during the acc_en_o cycle.
REQ-017 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS, ACK.
REQ-019 In IDLE with at least one req high, the block SHALL select a winner, register its wr/addr/wdata into wr_en_o/addr_o/wdata_o, and go to BUS next cycle.
REQ-020 If only one req is high, that master SHALL win.
REQ-021 If both reqs are high, the master named by the 1-bit round-robin pointer SHALL win (0 = m0).
REQ-022 In BUS, acc_en_o SHALL be 1 for exactly one cycle; wr_en_o SHALL equal the latched wr; rdata_i SHALL be captured at the end of that cycle.
REQ-023 In every cycle outside BUS, acc_en_o and wr_en_o SHALL be 0; addr_o/wdata_o SHALL hold their last values.
REQ-024 In ACK, only the winner's ack SHALL be 1 for one cycle.
REQ-025 On a read, the winner's rdata_o SHALL load the captured rdata_i on entering ACK.
REQ-026 On a write, both rdata_o outputs SHALL be unchanged.
REQ-027 On leaving ACK, the pointer SHALL be set to the non-winning master and the FSM SHALL return to IDLE.
REQ-028 Latency SHALL be fixed: req seen in IDLE at cycle N, acc_en_o at N+1, ack at N+2; max throughput is one transaction per 3 cycles.
REQ-029 Master inputs SHALL be sampled only in IDLE; changes after grant SHALL NOT affect the running access.
REQ-030 A req dropped before being sampled in IDLE SHALL be ignored; no ack is produced.
REQ-031 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-032 A master with req held continuously SHALL NOT block the other: under constant contention, grants SHALL alternate m0, m1, m0, and so on.

Reset
REQ-033 While rst_i is high: state = IDLE, pointer = 0, and acc_en_o, wr_en_o, addr_o, wdata_o, both acks, both rdata_o, and busy_o SHALL be 0 on the next edge.
REQ-034 Reset asserted in BUS or ACK SHALL abort the transaction: no ack is issued, and acc_en_o is 0 from the next cycle.
REQ-035 The first edge with rst_i low SHALL evaluate requests normally from IDLE.

Verification
REQ-036 Single write: m0 writes addr 2, data 0x01F4 -> acc_en_o = wr_en_o = 1 one cycle later with addr_o = 2 and wdata_o = 0x01F4; m0_ack_o the following cycle; m1_ack_o stays 0.
REQ-037 Single read: m1 reads addr 5 while rdata_i = 0x0123 in the BUS cycle -> m1_ack_o = 1 with m1_rdata_o = 0x0123; m0_rdata_o is unchanged.
REQ-038 Contention after reset: both reqs high continuously for 4 transactions -> grant order m0, m1, m0, m1; acks spaced 3 cycles apart.
REQ-039 Input change after grant: m0 raises req with wdata 0xAAAA, then changes wdata to 0x5555 in the BUS cycle -> wdata_o = 0xAAAA.
REQ-040 Reset in BUS: rst_i pulsed high while acc_en_o = 1 -> no ack; all outputs 0 next cycle; pointer = 0.
REQ-041 Dropped request: m1_req_i high for one cycle while the FSM is in BUS serving m0 -> no m1 transaction and m1_ack_o stays 0.
